// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB register usage and drives stalls, bubbles, freeze and forward selects.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [6:0]       id_op,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             flush,
   input  logic             mem_ready,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   logic       ex_valid_r, ex_wr_r, ex_load_r, ex_u1_r, ex_u2_r;
   logic [4:0] ex_rd_r, ex_rs1_r, ex_rs2_r;
   logic       mem_valid_r, mem_wr_r, mem_load_r;
   logic [4:0] mem_rd_r;
   logic       wb_valid_r, wb_wr_r;
   logic [4:0] wb_rd_r;

   logic uses_rs1_s, uses_rs2_s, writes_s, is_load_s;
   logic lu_s, mw_s;

   assign uses_rs2_s = ~id_op[2] & id_op[5] & (~id_op[6] | ~id_op[4]);
   assign uses_rs1_s = (id_op != OP_LUI) && (id_op != OP_AUIPC) && (id_op != OP_JAL);
   assign writes_s   = (id_op != OP_STORE) && (id_op != OP_BR) && (id_rd != 5'd0);
   assign is_load_s  = (id_op == OP_LOAD);

   assign lu_s = id_valid & ex_valid_r & ex_load_r & ex_wr_r &
                 ((uses_rs1_s & (id_rs1 == ex_rd_r)) | (uses_rs2_s & (id_rs2 == ex_rd_r)));
   assign mw_s = mem_valid_r & mem_load_r & ~mem_ready;

   // A stalled MEM load has no data yet, so it is masked as a source while mw is high.
   function automatic logic [1:0] fwd_sel(
      input logic       use_rs,
      input logic [4:0] rs,
      input logic       mem_ok,
      input logic [4:0] mem_rd,
      input logic       wb_ok,
      input logic [4:0] wb_rd
   );
      logic [1:0] sel;
      if (use_rs && mem_ok && (mem_rd == rs)) begin
         sel = 2'b10;
      end else if (use_rs && wb_ok && (wb_rd == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   logic mem_src_s, wb_src_s;
   assign mem_src_s = mem_valid_r & mem_wr_r & ~mw_s;
   assign wb_src_s  = wb_valid_r & wb_wr_r;

   assign fwd_a = fwd_sel(ex_valid_r & ex_u1_r, ex_rs1_r, mem_src_s, mem_rd_r, wb_src_s, wb_rd_r);
   assign fwd_b = fwd_sel(ex_valid_r & ex_u2_r, ex_rs2_r, mem_src_s, mem_rd_r, wb_src_s, wb_rd_r);

   // Control priority: memory wait, then flush, then load-use.
   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      freeze      = 1'b0;
      if (mw_s) begin
         freeze     = 1'b1;
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
      end else if (flush) begin
         bubble_idex = 1'b1;
      end else if (lu_s) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         bubble_idex = 1'b1;
      end else begin
         stall_pc    = 1'b0;
      end
   end

   // Shadow stage records advance with the pipe unless frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_r  <= 1'b0;
         ex_wr_r     <= 1'b0;
         ex_load_r   <= 1'b0;
         ex_u1_r     <= 1'b0;
         ex_u2_r     <= 1'b0;
         ex_rd_r     <= 5'd0;
         ex_rs1_r    <= 5'd0;
         ex_rs2_r    <= 5'd0;
         mem_valid_r <= 1'b0;
         mem_wr_r    <= 1'b0;
         mem_load_r  <= 1'b0;
         mem_rd_r    <= 5'd0;
         wb_valid_r  <= 1'b0;
         wb_wr_r     <= 1'b0;
         wb_rd_r     <= 5'd0;
      end else if (!freeze) begin
         wb_valid_r  <= mem_valid_r;
         wb_wr_r     <= mem_wr_r;
         wb_rd_r     <= mem_rd_r;
         mem_valid_r <= ex_valid_r;
         mem_wr_r    <= ex_wr_r;
         mem_load_r  <= ex_load_r;
         mem_rd_r    <= ex_rd_r;
         if (id_valid && !bubble_idex) begin
            ex_valid_r <= 1'b1;
            ex_wr_r    <= writes_s;
            ex_load_r  <= is_load_s;
            ex_u1_r    <= uses_rs1_s;
            ex_u2_r    <= uses_rs2_s;
            ex_rd_r    <= id_rd;
            ex_rs1_r   <= id_rs1;
            ex_rs2_r   <= id_rs2;
         end else begin
            ex_valid_r <= 1'b0;
            ex_wr_r    <= 1'b0;
            ex_load_r  <= 1'b0;
            ex_u1_r    <= 1'b0;
            ex_u2_r    <= 1'b0;
            ex_rd_r    <= 5'd0;
            ex_rs1_r   <= 5'd0;
            ex_rs2_r   <= 5'd0;
         end
      end else begin
         ex_valid_r <= ex_valid_r;
      end
   end

   // Saturating count of PC-stall cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= {CNT_W{1'b0}};
      end else if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, memory wait, flush, reset and saturation.
module tb_hazard_ctrl;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [6:0]  id_op = 7'd0;
   logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
   logic        flush = 1'b0;
   logic        mem_ready = 1'b1;
   logic        stall_pc, stall_ifid, bubble_idex, freeze;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt;
   logic        stall_pc4, stall_ifid4, bubble_idex4, freeze4;
   logic [1:0]  fwd_a4, fwd_b4;
   logic [3:0]  stall_cnt4;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .mem_ready(mem_ready), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .bubble_idex(bubble_idex), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .mem_ready(mem_ready), .stall_pc(stall_pc4), .stall_ifid(stall_ifid4),
      .bubble_idex(bubble_idex4), .freeze(freeze4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
      .stall_cnt(stall_cnt4)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic sp, input logic bb, input logic fz,
                          input logic [1:0] fa, input logic [1:0] fb);
      check_val({tag, ".stall_pc"}, {31'd0, stall_pc}, {31'd0, sp});
      check_val({tag, ".stall_ifid"}, {31'd0, stall_ifid}, {31'd0, sp});
      check_val({tag, ".bubble"}, {31'd0, bubble_idex}, {31'd0, bb});
      check_val({tag, ".freeze"}, {31'd0, freeze}, {31'd0, fz});
      check_val({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, fa});
      check_val({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, fb});
   endtask

   task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
      id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      repeat (3) step();
   endtask

   initial begin
      #2;
      chk_ctl("reset", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check_val("reset.cnt", {16'd0, stall_cnt}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x5,x4
      set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd5);
      chk_ctl("t1.add_id", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
      set_id(1'b1, OP_R, 5'd5, 5'd3, 5'd6);
      chk_ctl("t1.sub_id", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
      set_id(1'b1, OP_R, 5'd5, 5'd4, 5'd7);
      chk_ctl("t1.sub_ex", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk_ctl("t1.or_ex", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
      drain();

      // lw x5,0(x1) ; add x6,x1,x5
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5);
      chk_ctl("t2.lw_id", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
      set_id(1'b1, OP_R, 5'd1, 5'd5, 5'd6);
      chk_ctl("t2.lu", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
      step();
      chk_ctl("t2.after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check_val("t2.cnt", {16'd0, stall_cnt}, 32'd1);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk_ctl("t2.add_ex", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
      drain();

      // addi x0,x1,1 ; add x2,x0,x0
      set_id(1'b1, OP_I, 5'd1, 5'd0, 5'd0);
      step();
      set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd2);
      chk_ctl("t3.x0_id", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk_ctl("t3.x0_ex", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      drain();
      // lw x5 ; sw x5,0(x2)
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5);
      step();
      set_id(1'b1, OP_ST, 5'd2, 5'd5, 5'd0);
      chk_ctl("t3.sw_lu", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
      step();
      chk_ctl("t3.sw_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check_val("t3.cnt", {16'd0, stall_cnt}, 32'd2);
      drain();

      // addi x3 ; lw x8 ; add x9,x2,x3 ; add x10,x8,x1 with 3-cycle memory wait
      set_id(1'b1, OP_I, 5'd0, 5'd0, 5'd3);
      step();
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd8);
      step();
      set_id(1'b1, OP_R, 5'd2, 5'd3, 5'd9);
      chk_ctl("t4.add9_id", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step();
      set_id(1'b1, OP_R, 5'd8, 5'd1, 5'd10);
      mem_ready = 1'b0;
      #1;
      chk_ctl("t4.mw1", 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
      step();
      flush = 1'b1;
      #1;
      chk_ctl("t4.mw2_flush", 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
      step();
      flush = 1'b0;
      #1;
      chk_ctl("t4.mw3", 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
      step();
      mem_ready = 1'b1;
      #1;
      chk_ctl("t4.ready", 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
      check_val("t4.cnt", {16'd0, stall_cnt}, 32'd5);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk_ctl("t4.add10_ex", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
      drain();

      // lw x5 ; add x6,x5,x5 with flush in the same cycle
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5);
      step();
      set_id(1'b1, OP_R, 5'd5, 5'd5, 5'd6);
      flush = 1'b1;
      #1;
      chk_ctl("t5.flush_lu", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      step();
      flush = 1'b0;
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      chk_ctl("t5.ex_empty", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check_val("t5.cnt", {16'd0, stall_cnt}, 32'd5);
      drain();

      // reset during freeze
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      step();
      mem_ready = 1'b0;
      #1;
      check_val("t6.frozen", {31'd0, freeze}, 32'd1);
      rst = 1'b1;
      #1;
      chk_ctl("t6.rst", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      check_val("t6.cnt", {16'd0, stall_cnt}, 32'd0);
      check_val("t6.cnt4", {28'd0, stall_cnt4}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      check_val("t6.no_pending", {31'd0, freeze}, 32'd0);
      mem_ready = 1'b1;
      step();

      // 20-cycle memory wait: 16-bit counter reads 20, 4-bit counter saturates at 15
      set_id(1'b1, OP_LD, 5'd1, 5'd0, 5'd5);
      step();
      set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      step();
      mem_ready = 1'b0;
      repeat (20) step();
      check_val("t6.cnt20", {16'd0, stall_cnt}, 32'd20);
      check_val("t6.sat4", {28'd0, stall_cnt4}, 32'd15);
      mem_ready = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and forwarding controller for the 5-stage RV32I core.
- Sits beside the ID/EX/MEM/WB pipeline registers and keeps its own shadow copy of the register-usage info for the instructions in EX, MEM and WB.
- From the instruction in ID and that shadow state it produces: PC/IF-ID hold, ID/EX bubble insertion, whole-pipe freeze during data-memory wait, and the EX operand-forwarding selects.
- It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_op  in  7  opcode of the ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register fields of the ID instruction.
- flush  in  1  branch/jump taken, resolved in EX this cycle.
- mem_ready  in  1  data memory has completed the access of the MEM-stage load.
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB (memory wait).
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 from MEM, 01 from WB.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.

## Operation
Decode of id_op (combinational):
- uses_rs2 = ~op[2] & op[5] & (~op[6] | ~op[4]). This is true for R, S and B types.
- uses_rs1 = not (op == 0110111 LUI, 0010111 AUIPC, 1101111 JAL).
- writes = op not in {0100011 S, 1100011 B} and rd != 0.
- is_load = (op == 0000011).

Stage records EX, MEM and WB each hold: valid, rd, wr, load, rs1, rs2, u1, u2 (the u fields apply to EX only).

Hazard conditions:
- Load-use (lu): id_valid & EX.valid & EX.load & EX.wr & ((uses_rs1 & id_rs1 == EX.rd) | (uses_rs2 & id_rs2 == EX.rd)).
- Memory wait (mw): MEM.valid & MEM.load & ~mem_ready.

Output priority:
1. mw: freeze=1, stall_pc=1, stall_ifid=1, bubble_idex=0. All stage records hold. flush is ignored; its source holds it while frozen.
2. flush: bubble_idex=1, stall_pc=0, stall_ifid=0. lu is suppressed. The ID instruction is discarded.
3. lu: stall_pc=1, stall_ifid=1, bubble_idex=1.
4. Otherwise all outputs are 0.

Record advance when freeze=0:
- WB <- MEM and MEM <- EX.
- EX <- ID record if id_valid & ~bubble_idex, else an invalid record.

Forwarding for the EX instruction (fwd_a uses EX.rs1/u1; fwd_b uses EX.rs2/u2):
- 10 if EX.u & MEM.valid & MEM.wr & MEM.rd == EX.rs.
- Else 01 if the same condition holds for WB.
- Else 00.
- rd == 0 never matches, because wr is cleared at capture.
- An invalid EX record gives 00.
- A MEM-stage load is never a forward source while mw. After mw clears, forwarding from it is legal.

stall_cnt:
- Increments by 1 each cycle with stall_pc=1.
- Saturates at all-ones, with no wrap.

## Timing
- Reset (asynchronous, immediate): all records invalid, stall_cnt=0. All outputs therefore read 0 during and after reset.
- Every control output is combinational from the current records and inputs, so it is valid in the same cycle.
- Load-use costs exactly 1 stall cycle:
  - Cycle n: the load is in EX and the consumer is in ID, so lu=1.
  - Cycle n+1: the load is in MEM and a bubble is in EX. The consumer is still in ID with no lu.
  - Cycle n+2: the consumer is in EX with fwd=01 from the load in WB.
- A memory wait of k cycles gives freeze=1 for exactly k cycles. The pipe advances on the first edge where mem_ready=1.
- lu and mw in the same cycle: mw wins. lu is re-evaluated after the wait, and still stalls because the load remains in EX.
- Reset asserted mid-freeze or mid-stall: everything clears at once with no pending stall.
- Back-to-back load-use pairs each cost 1 cycle.

## Test plan
1. add x5,x1,x2 then sub x6,x5,x3 -> with sub in EX: fwd_a=10, no stall. One instruction later in WB: fwd_a=01.
2. lw x5,0(x1) then add x6,x1,x5 -> stall_pc/stall_ifid/bubble_idex=1 for one cycle. Then add in EX with fwd_b=01. stall_cnt=1.
3. addi x0,x1,1 then add x2,x0,x0 -> fwd_a=fwd_b=00, no stall. Also sw x5 after lw x5 -> 1-cycle stall, because uses_rs2=1 for opcode 0100011.
4. lw in MEM, mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles, stall_cnt+=3, records unchanged, fwd outputs stable.
5. lu condition with flush=1 in the same cycle -> bubble_idex=1, stall_pc=0, stall_cnt unchanged. The next EX record is invalid.
6. rst pulsed during freeze -> all outputs 0 at once. Also, with CNT_W=4 and 20 stall cycles, stall_cnt stays at 15.
